// File: rtl/adc_ddr_rx_align.sv
// rtl/adc_ddr_rx_align.sv - two-channel DDR sample rebuild, pattern training and loopback check
module adc_ddr_rx_align #(
  parameter int               WIDTH     = 14,
  parameter logic [WIDTH-1:0] PAT0      = 14'h1A5A,
  parameter logic [WIDTH-1:0] PAT1      = 14'h0DB6,
  parameter int               SETTLE    = 4,
  parameter int               TRAIN_CNT = 16,
  parameter int               ERR_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] Q1_in,
  input  logic [WIDTH-1:0] Q2_in,
  input  logic             align_start_in,
  input  logic             check_en_in,
  output logic [WIDTH-1:0] ADC0_out,
  output logic [WIDTH-1:0] ADC1_out,
  output logic             valid_out,
  output logic             locked_out,
  output logic             fail_out,
  output logic [1:0]       cfg_out,
  output logic [ERR_W-1:0] err_cnt_out
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(TRAIN_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cfg_q, cfg_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [MW-1:0]    match_q, match_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [WIDTH-1:0] q1_r, q2_r, q2_d;
  logic [WIDTH-1:0] pair_a, pair_b, ch0, ch1;
  logic             pair_ok;

  // cfg = {slip, swap}: slip pairs the previous falling word with the current rising word
  always_comb begin
    pair_a = q1_r;
    pair_b = q2_r;
    if (cfg_q[1]) begin
      pair_a = q2_d;
      pair_b = q1_r;
    end
    ch0 = pair_a;
    ch1 = pair_b;
    if (cfg_q[0]) begin
      ch0 = pair_b;
      ch1 = pair_a;
    end
  end

  assign pair_ok = (ADC0_out == PAT0) && (ADC1_out == PAT1);

  // Next-state logic: restart has priority over every other transition
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    settle_d = settle_q;
    match_d  = match_q;
    err_d    = err_q;
    if (align_start_in) begin
      state_d  = ST_SETTLE;
      cfg_d    = 2'd0;
      settle_d = '0;
      match_d  = '0;
      err_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SETTLE: begin
          if (settle_q == SW'(SETTLE - 1)) begin
            state_d  = ST_CHECK;
            settle_d = '0;
            match_d  = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (pair_ok) begin
            match_d = match_q + 1'b1;
            if (match_q == MW'(TRAIN_CNT - 1)) begin
              state_d = ST_LOCKED;
            end
          end else if (cfg_q != 2'd3) begin
            cfg_d    = cfg_q + 2'd1;
            settle_d = '0;
            state_d  = ST_SETTLE;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_LOCKED: begin
          if (check_en_in && !pair_ok && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Input capture, output alignment stage and control registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      q1_r     <= '0;
      q2_r     <= '0;
      q2_d     <= '0;
      ADC0_out <= '0;
      ADC1_out <= '0;
      state_q  <= ST_IDLE;
      cfg_q    <= 2'd0;
      settle_q <= '0;
      match_q  <= '0;
      err_q    <= '0;
    end else begin
      q1_r     <= Q1_in;
      q2_r     <= Q2_in;
      q2_d     <= q2_r;
      ADC0_out <= ch0;
      ADC1_out <= ch1;
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      err_q    <= err_d;
    end
  end

  assign valid_out   = (state_q == ST_LOCKED);
  assign locked_out  = (state_q == ST_LOCKED);
  assign fail_out    = (state_q == ST_FAIL);
  assign cfg_out     = cfg_q;
  assign err_cnt_out = err_q;

endmodule

// File: tb/tb_adc_ddr_rx_align.sv
// tb/tb_adc_ddr_rx_align.sv - scoreboard bench for adc_ddr_rx_align
module tb_adc_ddr_rx_align;

  localparam int          WIDTH     = 14;
  localparam logic [13:0] PAT0      = 14'h1A5A;
  localparam logic [13:0] PAT1      = 14'h0DB6;
  localparam int          SETTLE    = 4;
  localparam int          TRAIN_CNT = 16;
  localparam int          ERR_W     = 4;
  localparam int          ERR_MAX   = (1 << ERR_W) - 1;

  localparam int M_IDLE = 0, M_WAIT = 1, M_TRAIN = 2, M_LOCK = 3, M_FAIL = 4;

  logic             clk, rst;
  logic [13:0]      q1, q2;
  logic             start, chk_en;
  logic [13:0]      adc0, adc1;
  logic             valid, locked, fail;
  logic [1:0]       cfg;
  logic [ERR_W-1:0] err;

  adc_ddr_rx_align #(
    .WIDTH(WIDTH), .PAT0(PAT0), .PAT1(PAT1),
    .SETTLE(SETTLE), .TRAIN_CNT(TRAIN_CNT), .ERR_W(ERR_W)
  ) dut (
    .clk_in(clk), .rst_in(rst), .Q1_in(q1), .Q2_in(q2),
    .align_start_in(start), .check_en_in(chk_en),
    .ADC0_out(adc0), .ADC1_out(adc1), .valid_out(valid),
    .locked_out(locked), .fail_out(fail), .cfg_out(cfg), .err_cnt_out(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a0;
    logic [13:0] a1;
    logic        v;
    logic        l;
    logic        f;
    logic [1:0]  c;
    int          e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state: samples seen at the last two edges plus training progress
  logic [13:0] m_adc0, m_adc1, s_rise, s_fall, s_fall_old;
  logic [1:0]  m_cfg;
  int          m_mode, m_wait, m_hits, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_adc0 = '0; m_adc1 = '0; s_rise = '0; s_fall = '0; s_fall_old = '0;
    m_cfg = 2'd0; m_mode = M_IDLE; m_wait = 0; m_hits = 0; m_err = 0;
  endtask

  task automatic model_step();
    exp_t        e;
    logic [13:0] first, second;
    logic        good;
    if (!rst) begin
      model_reset();
    end else begin
      good = (m_adc0 == PAT0) && (m_adc1 == PAT1);
      first  = m_cfg[1] ? s_fall_old : s_rise;
      second = m_cfg[1] ? s_rise     : s_fall;
      m_adc0 = m_cfg[0] ? second : first;
      m_adc1 = m_cfg[0] ? first  : second;
      s_fall_old = s_fall;
      s_rise = q1;
      s_fall = q2;
      if (start) begin
        m_mode = M_WAIT; m_wait = SETTLE; m_cfg = 2'd0; m_hits = 0; m_err = 0;
      end else if (m_mode == M_WAIT) begin
        m_wait--;
        if (m_wait == 0) begin
          m_mode = M_TRAIN; m_hits = 0;
        end
      end else if (m_mode == M_TRAIN) begin
        if (good) begin
          m_hits++;
          if (m_hits == TRAIN_CNT) m_mode = M_LOCK;
        end else if (m_cfg == 2'd3) begin
          m_mode = M_FAIL;
        end else begin
          m_cfg = m_cfg + 2'd1; m_mode = M_WAIT; m_wait = SETTLE;
        end
      end else if (m_mode == M_LOCK) begin
        if (chk_en && !good && m_err < ERR_MAX) m_err++;
      end
    end
    e.a0 = m_adc0; e.a1 = m_adc1;
    e.v = (m_mode == M_LOCK); e.l = (m_mode == M_LOCK); e.f = (m_mode == M_FAIL);
    e.c = m_cfg; e.e = m_err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [13:0] junk();
    logic [13:0] v;
    v = 14'($urandom);
    while (v == PAT0 || v == PAT1) v = 14'($urandom);
    return v;
  endfunction

  // monitor: one expected entry per clock edge, compared on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("adc0", int'(adc0), int'(e.a0));
      chk("adc1", int'(adc1), int'(e.a1));
      chk("valid", int'(valid), int'(e.v));
      chk("locked", int'(locked), int'(e.l));
      chk("fail", int'(fail), int'(e.f));
      chk("cfg", int'(cfg), int'(e.c));
      chk("err_cnt", int'(err), e.e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: dut=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_at;
    model_reset();
    rst = 1'b0; start = 1'b0; chk_en = 1'b0; q1 = '0; q2 = '0;

    // T1 reset with random inputs
    for (int i = 0; i < 5; i++) begin
      q1 = 14'($urandom); q2 = 14'($urandom);
      tick();
    end
    rst = 1'b1;

    // T2 aligned stream, lock latency
    q1 = PAT0; q2 = PAT1;
    tick(); tick();
    start = 1'b1;
    lock_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      start = 1'b0;
      if (locked && lock_at < 0) lock_at = i;
    end
    chk("t2_lock_latency", lock_at, SETTLE + TRAIN_CNT + 1);
    chk("t2_cfg", int'(cfg), 0);

    // T5 error monitor: 3 isolated corruptions, then saturation
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q1 = PAT0 ^ 14'($urandom_range(1, 16383));
      tick();
      q1 = PAT0;
      tick(); tick();
    end
    tick(); tick();
    chk("t5_err3", int'(err), 3);
    for (int i = 0; i < 20; i++) begin
      q2 = PAT1 ^ 14'($urandom_range(1, 16383));
      tick();
    end
    q2 = PAT1;
    tick(); tick(); tick();
    chk("t5_err_sat", int'(err), ERR_MAX);
    chk("t5_still_locked", int'(locked), 1);

    // T6 restart in LOCKED
    pulse_start();
    chk("t6_unlock", int'(locked), 0);
    chk("t6_err_clr", int'(err), 0);
    chk("t6_cfg_clr", int'(cfg), 0);
    for (int i = 0; i < 25; i++) tick();
    chk("t6_relock", int'(locked), 1);

    // T6 restart mid-CHECK, then restart on the final matching edge
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    pulse_start();
    for (int i = 0; i < SETTLE + TRAIN_CNT - 1; i++) tick();
    pulse_start();
    chk("t6_final_match_restart", int'(locked), 0);
    for (int i = 0; i < 25; i++) tick();
    chk("t6_relock2", int'(locked), 1);

    // T3 swapped + slipped: only cfg 3 can see the pattern
    chk_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 70; i++) begin
      q1 = PAT0;
      q2 = (m_cfg == 2'd3) ? PAT1 : junk();
      tick();
    end
    chk("t3_locked", int'(locked), 1);
    chk("t3_cfg", int'(cfg), 3);
    chk("t3_adc0", int'(adc0), int'(PAT0));
    chk("t3_adc1", int'(adc1), int'(PAT1));

    // T4 no pattern present
    q1 = '0; q2 = '0;
    pulse_start();
    for (int i = 0; i < 4 * (SETTLE + 1) + 3; i++) tick();
    chk("t4_fail", int'(fail), 1);
    chk("t4_cfg", int'(cfg), 3);
    chk("t4_valid", int'(valid), 0);

    // reset mid-operation clears everything and does not restart training
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // randomized segments of aligned / swapped / noisy streams
    for (int seg = 0; seg < 40; seg++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 60; i++) begin
        case (mode)
          0: begin q1 = PAT0; q2 = PAT1; end
          1: begin q1 = PAT1; q2 = PAT0; end
          2: begin q1 = 14'($urandom); q2 = 14'($urandom); end
          default: begin
            q1 = ($urandom_range(0, 1) == 0) ? PAT0 : PAT1;
            q2 = ($urandom_range(0, 1) == 0) ? PAT1 : PAT0;
          end
        endcase
        if ($urandom_range(0, 99) < 4) q1 = 14'($urandom);
        start  = ($urandom_range(0, 99) < 2) || (i == 0);
        chk_en = $urandom_range(0, 1) == 1;
        rst    = $urandom_range(0, 199) != 0;
        tick();
      end
    end
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
